fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter AWIDTH, 32, instruction address width.
REQ-002 Parameter DWIDTH, 32, instruction word width.
REQ-003 Parameter DEPTH, 4, queue entries; power of two, minimum 2.
REQ-004 Parameter BASEADDR, 32'h01000000, first fetch address after reset.
REQ-005 The block uses one clock, clk; reset rst is asynchronous and active-low.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 redirect_i  input  1  control-flow redirect (taken branch/jump) from execute.
REQ-009 redirect_pc_i  input  AWIDTH  redirect target address.
REQ-010 imem_req_o  output  1  instruction memory read request.
REQ-011 imem_addr_o  output  AWIDTH  instruction memory read address.
REQ-012 imem_rdata_i  input  DWIDTH  read data; valid exactly one cycle after an issued request.
REQ-013 insn_valid_o  output  1  head entry valid toward decode.
REQ-014 insn_o  output  DWIDTH  head instruction word.
REQ-015 pc_o  output  AWIDTH  PC tag of head instruction.
REQ-016 insn_ready_i  input  1  decode accepts head this cycle.
REQ-017 count_o  output  $clog2(DEPTH+1)  occupied entries.

Function
REQ-018 Internal fetch_pc register holds the next address to request.
REQ-019 Request issue condition: rst high, redirect_i low, and (count + inflight) < DEPTH; imem_req_o reflects this combinationally.
REQ-020 imem_addr_o equals fetch_pc at all times; fetch_pc increments by 4 on each issued request, wrapping modulo 2^AWIDTH.
REQ-021 inflight flag is set the cycle after an issue and clear otherwise; at most one request is outstanding.
REQ-022 When inflight is set and no redirect is active, imem_rdata_i and its request address are written at the tail entry, and the tail pointer advances modulo DEPTH.
REQ-023 insn_valid_o equals (count != 0); insn_o and pc_o come from the head entry; when the queue is empty they drive zero.
REQ-024 Pop occurs when insn_valid_o and insn_ready_i are both high; the head pointer advances modulo DEPTH.
REQ-025 A simultaneous push and pop leaves count unchanged, and both pointers advance.
REQ-026 The credit rule in REQ-019 guarantees no push when the queue is full; an overflow is a design error and shall be flagged by an assertion.
REQ-027 On redirect_i high at a clock edge: fetch_pc loads {redirect_pc_i[AWIDTH-1:2],2'b00}, count and both pointers clear to 0, the in-flight response is discarded, and no request is issued that cycle.
REQ-028 A pop handshake in the redirect cycle is treated as consumed; redirect takes priority over push.
REQ-029 First-word latency after reset release or redirect is 2 cycles: request in cycle N, entry written at edge N+1, insn_valid_o high in cycle N+1.
REQ-030 Steady-state throughput with insn_ready_i held high is one instruction per cycle.

Reset
REQ-031 While rst is low: fetch_pc=BASEADDR, inflight=0, count=0, pointers=0, insn_valid_o=0, insn_o=0, pc_o=0, count_o=0, imem_req_o=0.
REQ-032 Reset asserted mid-operation clears state immediately (asynchronously), and queued and in-flight words are lost.
REQ-033 The first request after reset release addresses BASEADDR.

Verification
REQ-034 Release reset with insn_ready_i=1 and memory returning the address as data -> imem_addr_o sequence 0x01000000, 0x01000004, ...; insn_valid_o rises in the second cycle; pc_o and insn_o match each other.
REQ-035 Hold insn_ready_i=0 -> exactly 4 requests issued, count_o=4, imem_req_o=0 thereafter; raise insn_ready_i -> words popped in order 0x01000000..0x0100000C with no loss or duplication.
REQ-036 Assert redirect_i with redirect_pc_i=0x01000043 while count_o=3 and inflight=1 -> next cycle count_o=0; next imem_addr_o=0x01000040; the stale in-flight word never appears on insn_o.
REQ-037 Full queue with simultaneous pop and pending push -> count_o stays 4; the pointer wraps from 3 to 0; the overflow assertion never fires.
REQ-038 Assert rst low for one cycle mid-stream -> all outputs drop to zero asynchronously; after release the first imem_addr_o is 0x01000000.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-queue signal bundle: redirect input, instruction-memory port and decode-side handshake.
// The master modport is the fetch queue itself; the slave modport is its environment.
interface fetch_queue_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              redirect_i;
  logic [AWIDTH-1:0] redirect_pc_i;
  logic              imem_req_o;
  logic [AWIDTH-1:0] imem_addr_o;
  logic [DWIDTH-1:0] imem_rdata_i;
  logic              insn_valid_o;
  logic [DWIDTH-1:0] insn_o;
  logic [AWIDTH-1:0] pc_o;
  logic              insn_ready_i;
  logic [CW-1:0]     count_o;

  modport master (
    input  redirect_i, redirect_pc_i, imem_rdata_i, insn_ready_i,
    output imem_req_o, imem_addr_o, insn_valid_o, insn_o, pc_o, count_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, imem_rdata_i, insn_ready_i,
    input  imem_req_o, imem_addr_o, insn_valid_o, insn_o, pc_o, count_o
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: sequential prefetch into a small FIFO, one request outstanding,
// credit-limited so a returning word always has a free slot; redirect flushes everything.
module fetch_queue #(
  parameter int                AWIDTH   = 32,
  parameter int                DWIDTH   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h0100_0000)
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master fq
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AWIDTH-1:0] fetch_pc;
  logic [AWIDTH-1:0] req_addr_p1;
  logic              inflight;
  logic [CW-1:0]     count;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [DWIDTH-1:0] insn_q [DEPTH];
  logic [AWIDTH-1:0] pc_q   [DEPTH];
  logic [CW:0]       occupancy;
  logic              issue;
  logic              push;
  logic              pop;
  logic              has_head;

  // Occupancy counts the outstanding request as a reserved slot.
  always_comb begin
    occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    issue     = rst && !fq.redirect_i && (occupancy < (CW+1)'(DEPTH));
    push      = inflight && !fq.redirect_i;
    has_head  = (count != '0);
    pop       = has_head && fq.insn_ready_i;
  end

  assign fq.imem_req_o   = issue;
  assign fq.imem_addr_o  = fetch_pc;
  assign fq.insn_valid_o = has_head;
  assign fq.insn_o       = has_head ? insn_q[head] : '0;
  assign fq.pc_o         = has_head ? pc_q[head]   : '0;
  assign fq.count_o      = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= BASEADDR;
      inflight <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (fq.redirect_i) begin
      fetch_pc <= {fq.redirect_pc_i[AWIDTH-1:2], 2'b00};
      inflight <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= issue;
      if (issue) fetch_pc <= fetch_pc + AWIDTH'(4);
      if (push)  tail     <= tail + PW'(1);
      if (pop)   head     <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Request stage p0 -> response stage p1: the address travels with the outstanding request.
  always_ff @(posedge clk) begin
    if (issue) req_addr_p1 <= fetch_pc;
    if (push) begin
      insn_q[tail] <= fq.imem_rdata_i;
      pc_q[tail]   <= req_addr_p1;
    end
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!rst)
    push |-> (count < CW'(DEPTH)))
    else $error("fetch_queue overflow: push into a full queue");
endmodule

// File: tb/tb_fetch_queue.sv
// Directed and randomized bench for fetch_queue, checked cycle by cycle against a queue-based model.
module tb_fetch_queue;
  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0100_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH)) fq ();

  fetch_queue #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH), .BASEADDR(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .fq  (fq)
  );

  int          checks   = 0;
  int          failures = 0;
  ent_t        mq[$];
  logic [31:0] m_fpc;
  bit          m_infl;
  logic [31:0] m_iaddr;
  logic [31:0] m_idata;
  logic [31:0] key;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fpc  = BASE;
    m_infl = 1'b0;
  endtask

  // Check all outputs before the edge, then advance the model and drive the memory response.
  task automatic cycle();
    bit exp_req;
    bit do_pop;
    @(negedge clk);
    exp_req = rst && !fq.redirect_i && ((mq.size() + int'(m_infl)) < DEPTH);
    do_pop  = (mq.size() != 0) && fq.insn_ready_i;
    chk("imem_req",   fq.imem_req_o,   exp_req);
    chk("imem_addr",  fq.imem_addr_o,  m_fpc);
    chk("insn_valid", fq.insn_valid_o, mq.size() != 0);
    chk("count",      fq.count_o,      mq.size());
    if (mq.size() != 0) begin
      chk("insn", fq.insn_o, mq[0].insn);
      chk("pc",   fq.pc_o,   mq[0].pc);
    end else begin
      chk("insn_empty", fq.insn_o, 0);
      chk("pc_empty",   fq.pc_o,   0);
    end
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else if (fq.redirect_i) begin
      mq.delete();
      m_fpc  = {fq.redirect_pc_i[31:2], 2'b00};
      m_infl = 1'b0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (m_infl) mq.push_back('{pc: m_iaddr, insn: m_idata});
      if (exp_req) begin
        m_iaddr = m_fpc;
        m_fpc   = m_fpc + 32'd4;
      end
      m_infl = exp_req;
    end
    #1;
    if (m_infl) begin
      m_idata         = m_iaddr ^ key;
      fq.imem_rdata_i = m_idata;
    end else begin
      fq.imem_rdata_i = $urandom;
    end
  endtask

  initial begin
    int guard;
    fq.redirect_i    = 1'b0;
    fq.redirect_pc_i = '0;
    fq.insn_ready_i  = 1'b1;
    fq.imem_rdata_i  = '0;
    key              = '0;
    model_reset();

    repeat (3) cycle();

    // Release reset: sequential fetch from BASE with address-as-data memory.
    rst = 1'b1;
    chk("first_addr_after_reset", fq.imem_addr_o, BASE);
    repeat (12) cycle();

    // Mid-stream asynchronous reset, checked before any clock edge.
    rst = 1'b0;
    #2;
    chk("arst_req",   fq.imem_req_o,   0);
    chk("arst_valid", fq.insn_valid_o, 0);
    chk("arst_insn",  fq.insn_o,       0);
    chk("arst_pc",    fq.pc_o,         0);
    chk("arst_count", fq.count_o,      0);
    chk("arst_addr",  fq.imem_addr_o,  BASE);
    model_reset();
    cycle();
    rst = 1'b1;
    fq.insn_ready_i = 1'b0;
    chk("addr_after_arst", fq.imem_addr_o, BASE);

    // Fill with decode stalled: exactly DEPTH entries, then requests stop.
    repeat (10) cycle();
    chk("fill_count", fq.count_o,    4);
    chk("fill_req",   fq.imem_req_o, 0);
    fq.insn_ready_i = 1'b1;
    chk("drain_first_word", fq.insn_o, BASE);
    repeat (10) cycle();

    // Redirect with three queued words and one in flight.
    key              = 32'hDEAD_0000;
    fq.insn_ready_i  = 1'b0;
    fq.redirect_i    = 1'b1;
    fq.redirect_pc_i = 32'h0000_2000;
    cycle();
    fq.redirect_i = 1'b0;
    guard = 0;
    while (!((mq.size() == 3) && m_infl) && (guard < 20)) begin
      cycle();
      guard++;
    end
    chk("reach_count3_inflight", fq.count_o, 3);
    key              = 32'h5A5A_0000;
    fq.redirect_i    = 1'b1;
    fq.redirect_pc_i = 32'h0100_0043;
    cycle();
    fq.redirect_i = 1'b0;
    chk("redirect_count", fq.count_o,     0);
    chk("redirect_addr",  fq.imem_addr_o, 32'h0100_0040);
    fq.insn_ready_i = 1'b1;
    repeat (8) cycle();

    // Full queue with alternating stall/pop keeps pointers wrapping.
    fq.insn_ready_i = 1'b0;
    repeat (8) cycle();
    for (int i = 0; i < 16; i++) begin
      fq.insn_ready_i = i[0];
      cycle();
    end
    fq.insn_ready_i = 1'b1;
    repeat (6) cycle();

    // Fetch address wraps past the top of the address space.
    fq.redirect_i    = 1'b1;
    fq.redirect_pc_i = 32'hFFFF_FFF6;
    cycle();
    fq.redirect_i = 1'b0;
    repeat (8) cycle();

    // Randomized traffic.
    key = $urandom;
    for (int i = 0; i < 500; i++) begin
      fq.insn_ready_i  = ($urandom_range(0, 3) != 0);
      fq.redirect_i    = ($urandom_range(0, 15) == 0);
      fq.redirect_pc_i = $urandom;
      if ((i % 64) == 63) key = $urandom;
      cycle();
    end
    fq.redirect_i = 1'b0;
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
